// File: rtl/i2s_rx.sv
// I2S-style serial audio receiver.
// Oversamples bclk/lrck/din with clk and deserialises left-justified stereo
// frames, WIDTH bits per slot. It presents each complete left/right pair with
// a one-cycle valid strobe. It also tracks framing lock and counts framing
// errors with a saturating counter.
module i2s_rx #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 256,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i2s_bclk,
  input  logic             i2s_lrck,
  input  logic             i2s_din,
  output logic [WIDTH-1:0] audio_l,
  output logic [WIDTH-1:0] audio_r,
  output logic             valid,
  output logic             locked,
  output logic [7:0]       err_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);

  logic [SYNC_STAGES-1:0] bclk_sync_q, lrck_sync_q, din_sync_q;
  logic                   bclk_prev_q;
  logic                   bclk_s, lr_s, din_s, strobe;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ovr_q, ovr_d;
  logic             prev_lr_q, prev_lr_d;
  logic             left_ok_q, left_ok_d;
  logic [WIDTH-1:0] left_stage_q, left_stage_d;
  logic [WIDTH-1:0] right_stage_q, right_stage_d;
  logic             commit_q, commit_d;
  logic [GW-1:0]    good_cnt_q, good_cnt_d;
  logic [TW-1:0]    to_cnt_q, to_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] audio_l_q, audio_l_d;
  logic [WIDTH-1:0] audio_r_q, audio_r_d;
  logic             valid_q, valid_d;

  assign bclk_s = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s   = lrck_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];
  // Falling edge of the synchronised bit clock is the data sample point.
  assign strobe = bclk_prev_q & ~bclk_s;

  // Synchronise the asynchronous I2S pins; all three see equal delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      din_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync_q <= {lrck_sync_q[SYNC_STAGES-2:0], i2s_lrck};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], i2s_din};
      bclk_prev_q <= bclk_s;
    end
  end

  // Next-state logic: deserialiser, framing checks, lock and timeout.
  always_comb begin
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    ovr_d         = ovr_q;
    prev_lr_d     = prev_lr_q;
    left_ok_d     = left_ok_q;
    left_stage_d  = left_stage_q;
    right_stage_d = right_stage_q;
    commit_d      = 1'b0;
    good_cnt_d    = good_cnt_q;
    to_cnt_d      = to_cnt_q;
    err_cnt_d     = err_cnt_q;
    audio_l_d     = audio_l_q;
    audio_r_d     = audio_r_q;
    valid_d       = 1'b0;

    // A complete pair was staged last cycle: publish both channels at once.
    if (commit_q) begin
      audio_l_d = left_stage_q;
      audio_r_d = right_stage_q;
      valid_d   = 1'b1;
      left_ok_d = 1'b0;
      if (good_cnt_q != GW'(LOCK_FRAMES)) good_cnt_d = good_cnt_q + GW'(1);
    end

    if (strobe) begin
      to_cnt_d  = '0;
      prev_lr_d = lr_s;
      if (lr_s != prev_lr_q) begin
        // New slot; a nonzero count means the previous slot was short or overran.
        if (bit_cnt_q != '0) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          good_cnt_d = '0;
          left_ok_d  = 1'b0;
        end
        shift_d   = {{(WIDTH-1){1'b0}}, din_s};
        bit_cnt_d = CW'(1);
        ovr_d     = 1'b0;
      end else begin
        shift_d = {shift_q[WIDTH-2:0], din_s};
        // After a slot completes, extra bits only leave a nonzero marker so the
        // next lrck edge flags the overrun; they never complete a second channel.
        bit_cnt_d = ovr_q ? CW'(1) : bit_cnt_q + CW'(1);
      end
      if (bit_cnt_d == CW'(WIDTH)) begin
        bit_cnt_d = '0;
        ovr_d     = 1'b1;
        if (!lr_s) begin
          left_stage_d = shift_d;
          left_ok_d    = 1'b1;
        end else if (left_ok_q) begin
          right_stage_d = shift_d;
          commit_d      = 1'b1;
        end
      end
    end else if (to_cnt_q != TW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (to_cnt_d == TW'(TIMEOUT)) begin
        good_cnt_d = '0;
        left_ok_d  = 1'b0;
        bit_cnt_d  = '0;
        ovr_d      = 1'b0;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      ovr_q         <= 1'b0;
      prev_lr_q     <= 1'b0;
      left_ok_q     <= 1'b0;
      left_stage_q  <= '0;
      right_stage_q <= '0;
      commit_q      <= 1'b0;
      good_cnt_q    <= '0;
      to_cnt_q      <= '0;
      err_cnt_q     <= '0;
      audio_l_q     <= '0;
      audio_r_q     <= '0;
      valid_q       <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      ovr_q         <= ovr_d;
      prev_lr_q     <= prev_lr_d;
      left_ok_q     <= left_ok_d;
      left_stage_q  <= left_stage_d;
      right_stage_q <= right_stage_d;
      commit_q      <= commit_d;
      good_cnt_q    <= good_cnt_d;
      to_cnt_q      <= to_cnt_d;
      err_cnt_q     <= err_cnt_d;
      audio_l_q     <= audio_l_d;
      audio_r_q     <= audio_r_d;
      valid_q       <= valid_d;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign valid   = valid_q;
  assign locked  = (good_cnt_q == GW'(LOCK_FRAMES));
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: bit clock period 20 clk, data launched on the
// bclk rising edge and sampled by the DUT on the falling edge.
module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk, lrck, din;
  logic [15:0] audio_l, audio_r;
  logic        valid, locked;
  logic [7:0]  err_cnt;

  int ncmp  = 0;
  int nfail = 0;
  int vcnt  = 0;
  logic [15:0] last_l = '0, last_r = '0;
  logic [15:0] tmp;

  i2s_rx #(.WIDTH(16), .SYNC_STAGES(2), .TIMEOUT(256), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .i2s_bclk(bclk), .i2s_lrck(lrck), .i2s_din(din),
    .audio_l(audio_l), .audio_r(audio_r), .valid(valid), .locked(locked),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Record every valid pulse and the pair presented with it.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt   = vcnt + 1;
      last_l = audio_l;
      last_r = audio_r;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit: low half, rise with new lrck/din, high half, fall (sample point).
  task automatic send_bit(input logic lr, input logic d);
    repeat (10) @(negedge clk);
    bclk = 1'b1; lrck = lr; din = d;
    repeat (10) @(negedge clk);
    bclk = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    for (int i = 15; i >= 0; i--) send_bit(1'b0, l[i]);
    for (int i = 15; i >= 0; i--) send_bit(1'b1, r[i]);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b0; lrck = 1'b0; din = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_audio_l", 32'(audio_l), 32'h0);
    chk("rst_audio_r", 32'(audio_r), 32'h0);
    chk("rst_valid",   32'(valid),   32'h0);
    chk("rst_locked",  32'(locked),  32'h0);
    chk("rst_err",     32'(err_cnt), 32'h0);
    rst = 1'b0;

    // Basic capture with exact latency: valid 4 clk after the right LSB falls.
    send_frame(16'h1234, 16'hABCD);
    repeat (3) @(negedge clk);
    chk("lat_early_valid", 32'(valid), 32'h0);
    @(negedge clk);
    chk("lat_valid",   32'(valid),   32'h1);
    chk("f1_audio_l",  32'(audio_l), 32'h1234);
    chk("f1_audio_r",  32'(audio_r), 32'hABCD);
    chk("f1_locked",   32'(locked),  32'h0);
    send_frame(16'h1234, 16'hABCD);
    repeat (4) @(negedge clk);
    chk("f2_valid",    32'(valid),   32'h1);
    chk("f2_locked",   32'(locked),  32'h1);
    send_frame(16'h1234, 16'hABCD);
    send_frame(16'h1234, 16'hABCD);
    settle();
    chk("f4_vcnt",     vcnt,         32'd4);
    chk("f4_err",      32'(err_cnt), 32'h0);
    chk("f4_audio_l",  32'(last_l),  32'h1234);
    chk("f4_audio_r",  32'(last_r),  32'hABCD);

    // MSB/LSB extremes.
    send_frame(16'h8000, 16'h7FFF);
    settle();
    chk("msb_l", 32'(last_l), 32'h8000);
    chk("msb_r", 32'(last_r), 32'h7FFF);
    send_frame(16'hFFFF, 16'h0001);
    settle();
    chk("lsb_l", 32'(last_l), 32'hFFFF);
    chk("lsb_r", 32'(last_r), 32'h0001);
    chk("ext_vcnt", vcnt, 32'd6);

    // Short left slot (10 bits): error and lock loss on the first right bit.
    tmp = 16'hC3C3;
    for (int i = 15; i >= 6; i--) send_bit(1'b0, tmp[i]);
    tmp = 16'h5A5A;
    send_bit(1'b1, tmp[15]);
    repeat (2) @(negedge clk);
    chk("short_pre_err",    32'(err_cnt), 32'h0);
    chk("short_pre_locked", 32'(locked),  32'h1);
    @(negedge clk);
    chk("short_err",    32'(err_cnt), 32'h1);
    chk("short_locked", 32'(locked),  32'h0);
    for (int i = 14; i >= 0; i--) send_bit(1'b1, tmp[i]);
    settle();
    chk("short_no_valid", vcnt, 32'd6);
    send_frame(16'h5555, 16'hAAAA);
    settle();
    chk("relock1_vcnt",   vcnt,          32'd7);
    chk("relock1_locked", 32'(locked),   32'h0);
    chk("relock1_l",      32'(last_l),   32'h5555);
    chk("relock1_r",      32'(last_r),   32'hAAAA);
    send_frame(16'h5555, 16'hAAAA);
    settle();
    chk("relock2_locked", 32'(locked),   32'h1);
    chk("relock2_err",    32'(err_cnt),  32'h1);

    // bclk stops mid right slot; lock drops exactly 256 clk after the last strobe.
    tmp = 16'h0F0F;
    for (int i = 15; i >= 0; i--) send_bit(1'b0, tmp[i]);
    tmp = 16'hF0F0;
    for (int i = 15; i >= 8; i--) send_bit(1'b1, tmp[i]);
    repeat (258) @(negedge clk);
    chk("to_pre_locked", 32'(locked), 32'h1);
    @(negedge clk);
    chk("to_locked",  32'(locked),  32'h0);
    chk("to_err",     32'(err_cnt), 32'h1);
    chk("to_hold_l",  32'(audio_l), 32'h5555);
    chk("to_hold_r",  32'(audio_r), 32'hAAAA);
    repeat (41) @(negedge clk);
    send_frame(16'h2468, 16'h1357);
    settle();
    chk("to_res_vcnt",   vcnt,        32'd9);
    chk("to_res_l",      32'(last_l), 32'h2468);
    chk("to_res_r",      32'(last_r), 32'h1357);
    chk("to_res_locked", 32'(locked), 32'h0);
    send_frame(16'h2468, 16'h1357);
    settle();
    chk("to_relock",     32'(locked),  32'h1);
    chk("to_res_err",    32'(err_cnt), 32'h1);

    // Reset, then the stream starts in a right slot.
    rst = 1'b1;
    @(negedge clk);
    chk("rst2_err",    32'(err_cnt), 32'h0);
    chk("rst2_locked", 32'(locked),  32'h0);
    chk("rst2_l",      32'(audio_l), 32'h0);
    rst = 1'b0;
    tmp = 16'hFACE;
    for (int i = 15; i >= 0; i--) send_bit(1'b1, tmp[i]);
    settle();
    chk("rstart_discard", vcnt, 32'd10);
    send_frame(16'h0BAD, 16'hF00D);
    settle();
    chk("rstart_vcnt", vcnt,          32'd11);
    chk("rstart_l",    32'(last_l),   32'h0BAD);
    chk("rstart_r",    32'(last_r),   32'hF00D);
    chk("rstart_err",  32'(err_cnt),  32'h0);

    // One-cycle reset in the middle of a right slot.
    send_frame(16'h0BAD, 16'hF00D);
    settle();
    chk("mid_pre_locked", 32'(locked), 32'h1);
    tmp = 16'h1111;
    for (int i = 15; i >= 0; i--) send_bit(1'b0, tmp[i]);
    tmp = 16'h2222;
    for (int i = 15; i >= 8; i--) send_bit(1'b1, tmp[i]);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_l",      32'(audio_l), 32'h0);
    chk("mid_rst_r",      32'(audio_r), 32'h0);
    chk("mid_rst_valid",  32'(valid),   32'h0);
    chk("mid_rst_locked", 32'(locked),  32'h0);
    chk("mid_rst_err",    32'(err_cnt), 32'h0);
    rst = 1'b0;
    for (int i = 7; i >= 0; i--) send_bit(1'b1, tmp[i]);
    settle();
    chk("mid_no_valid", vcnt, 32'd12);
    send_frame(16'hCAFE, 16'hBEEF);
    settle();
    chk("mid_res_vcnt", vcnt,        32'd13);
    chk("mid_res_l",    32'(last_l), 32'hCAFE);
    chk("mid_res_r",    32'(last_r), 32'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
